// File: rtl/router_pkg.sv
// Shared constants for the router output path.
// Header layout, default widths and a clog2 helper.
package router_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LEN_LSB = 2;
    localparam int ADDR_W_HDR = 2;
    localparam int TIMEOUT_DEF = 30;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/router_fifo_pkt_ctr.sv
// Read-side packet length tracker and output register.
// Ports: clk, rst_n, flush, rd_acc, rd_entry in; dout, dout_valid, pkt_busy out.
module router_fifo_pkt_ctr
    import router_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              rd_acc,
    input  logic [DATA_W:0]   rd_entry,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              pkt_busy
);

    localparam int CW = DATA_W - 1;

    logic [CW-1:0]            cnt_q, cnt_d;
    logic [DATA_W-1:0]        dout_q, dout_d;
    logic                     dv_q, dv_d;
    logic [DATA_W-LEN_LSB-1:0] len;

    assign len = rd_entry[DATA_W-1:LEN_LSB];

    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        dv_d   = 1'b0;
        if (flush) begin
            cnt_d  = '0;
            dout_d = '0;
        end else if (rd_acc) begin
            dout_d = rd_entry[DATA_W-1:0];
            dv_d   = 1'b1;
            // header reloads payload length plus the trailing parity byte
            if (rd_entry[DATA_W]) begin
                cnt_d = CW'(len) + CW'(1);
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end else if (cnt_q == '0) begin
            // outside a packet the output bus is parked at zero
            dout_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dout_q <= '0;
            dv_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            dv_q   <= dv_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign pkt_busy   = (cnt_q != '0);

endmodule

// File: rtl/router_fifo_flex.sv
// Parametrised per-port output FIFO with occupancy flags and read timeout.
// Ports: write side (w_en, lfd_state, din), read side (r_en, dout, dout_valid), status flags.
module router_fifo_flex
    import router_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  soft_rst,
    input  logic                  w_en,
    input  logic                  lfd_state,
    input  logic [DATA_W-1:0]     din,
    input  logic                  r_en,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [clog2(DEPTH):0] count,
    output logic                  pkt_busy,
    output logic                  overflow,
    output logic                  timeout
);

    localparam int AW   = clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int TO_W = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;

    localparam logic [AW:0]     AF_LVL  = CW'(DEPTH - AF_MARGIN);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [DATA_W:0]   mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [TO_W-1:0]   idle_q, idle_d;
    logic              ovf_q, ovf_d;
    logic              to_q, to_d;
    logic              wr_acc, rd_acc;
    logic              idle_cyc, fire, flush;

    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count       = wr_ptr_q - rd_ptr_q;
    assign almost_full = (count >= AF_LVL);

    assign wr_acc   = w_en && !full;
    assign rd_acc   = r_en && !empty;
    assign idle_cyc = !empty && !rd_acc;
    // timeout flush behaves exactly like soft_rst on the next edge
    assign fire     = (TIMEOUT > 0) && idle_cyc && (idle_q == TO_LAST);
    assign flush    = soft_rst || fire;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        idle_d   = '0;
        ovf_d    = 1'b0;
        to_d     = fire && !soft_rst;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + CW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + CW'(1);
            end
            ovf_d = w_en && full;
            if ((TIMEOUT > 0) && idle_cyc) begin
                idle_d = idle_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            idle_q   <= '0;
            ovf_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            idle_q   <= idle_d;
            ovf_q    <= ovf_d;
            to_q     <= to_d;
        end
    end

    // storage is never cleared, only the pointers are
    always_ff @(posedge clk) begin
        if (wr_acc && !flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, din};
        end
    end

    router_fifo_pkt_ctr #(
        .DATA_W (DATA_W)
    ) u_pkt_ctr (
        .clk        (clk),
        .rst_n      (rst),
        .flush      (flush),
        .rd_acc     (rd_acc),
        .rd_entry   (mem_q[rd_ptr_q[AW-1:0]]),
        .dout       (dout),
        .dout_valid (dout_valid),
        .pkt_busy   (pkt_busy)
    );

    assign overflow = ovf_q;
    assign timeout  = to_q;

endmodule

// File: tb/tb_router_fifo_flex.sv
// Self-checking bench for router_fifo_flex.
// Queue-based reference model plus directed tables and sequences.
module tb_router_fifo_flex;

    localparam int DEPTH = 16;
    localparam int TO    = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       soft_rst = 1'b0;
    logic       w_en = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] din = '0;
    logic       r_en = 1'b0;

    logic [7:0] dout, dout_b;
    logic       dout_valid, dout_valid_b;
    logic       full, full_b, empty, empty_b;
    logic       almost_full, almost_full_b;
    logic [4:0] count, count_b;
    logic       pkt_busy, pkt_busy_b;
    logic       overflow, overflow_b;
    logic       timeout, timeout_b;

    router_fifo_flex #(.DATA_W(8), .DEPTH(DEPTH), .AF_MARGIN(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .soft_rst(soft_rst), .w_en(w_en),
        .lfd_state(lfd_state), .din(din), .r_en(r_en),
        .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count), .pkt_busy(pkt_busy),
        .overflow(overflow), .timeout(timeout)
    );

    router_fifo_flex #(.DATA_W(8), .DEPTH(DEPTH), .AF_MARGIN(2), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst), .soft_rst(soft_rst), .w_en(w_en),
        .lfd_state(lfd_state), .din(din), .r_en(r_en),
        .dout(dout_b), .dout_valid(dout_valid_b), .full(full_b), .empty(empty_b),
        .almost_full(almost_full_b), .count(count_b), .pkt_busy(pkt_busy_b),
        .overflow(overflow_b), .timeout(timeout_b)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [8:0] q[$];
    int         m_cnt;
    logic [7:0] m_dout;
    bit         m_dv, m_ovf, m_to;
    int         m_idle;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt = 0; m_dout = '0; m_dv = 0;
        m_ovf = 0; m_to = 0; m_idle = 0;
    endtask

    task automatic model_step(input bit w, input bit l, input logic [7:0] d,
                              input bit r, input bit s);
        bit m_empty, m_full, rd, wr, idle, fire;
        logic [8:0] e;
        m_empty = (q.size() == 0);
        m_full  = (q.size() == DEPTH);
        rd   = r && !m_empty;
        wr   = w && !m_full;
        idle = !m_empty && !rd;
        fire = idle && (m_idle == TO - 1);
        if (s || fire) begin
            q.delete();
            m_cnt = 0; m_dout = '0; m_dv = 0;
            m_idle = 0; m_ovf = 0;
            m_to = fire && !s;
        end else begin
            m_ovf = w && m_full;
            m_to  = 0;
            if (rd) begin
                e = q.pop_front();
                m_dout = e[7:0];
                m_dv = 1;
                if (e[8]) m_cnt = int'(e[7:2]) + 1;
                else if (m_cnt != 0) m_cnt--;
            end else begin
                m_dv = 0;
                if (m_cnt == 0) m_dout = '0;
            end
            if (wr) q.push_back({l, d});
            m_idle = idle ? m_idle + 1 : 0;
        end
    endtask

    task automatic cmp_all();
        chk("dout", dout, m_dout);
        chk("dout_valid", dout_valid, m_dv);
        chk("count", count, q.size());
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == DEPTH);
        chk("almost_full", almost_full, q.size() >= DEPTH - 2);
        chk("pkt_busy", pkt_busy, m_cnt != 0);
        chk("overflow", overflow, m_ovf);
        chk("timeout", timeout, m_to);
    endtask

    task automatic step(input bit w, input bit l, input logic [7:0] d,
                        input bit r, input bit s);
        w_en = w; lfd_state = l; din = d; r_en = r; soft_rst = s;
        model_step(w, l, d, r, s);
        @(posedge clk);
        #1;
        cmp_all();
        w_en = 0; lfd_state = 0; r_en = 0; soft_rst = 0;
    endtask

    typedef struct {
        bit         w;
        bit         lfd;
        logic [7:0] d;
        bit         r;
        logic [7:0] e_dout;
        bit         e_dv;
        int         e_cnt;
        bit         e_busy;
    } vec_t;

    vec_t tbl[11];
    bit   seen, seen_b;
    int   idle_edges;
    logic [7:0] exp_q[$];
    logic [7:0] ed;

    initial begin
        tbl[0]  = '{1, 1, 8'h0D, 0, 8'h00, 0, 1, 0};
        tbl[1]  = '{1, 0, 8'h11, 0, 8'h00, 0, 2, 0};
        tbl[2]  = '{1, 0, 8'h22, 0, 8'h00, 0, 3, 0};
        tbl[3]  = '{1, 0, 8'h33, 0, 8'h00, 0, 4, 0};
        tbl[4]  = '{1, 0, 8'h5A, 0, 8'h00, 0, 5, 0};
        tbl[5]  = '{0, 0, 8'h00, 1, 8'h0D, 1, 4, 1};
        tbl[6]  = '{0, 0, 8'h00, 1, 8'h11, 1, 3, 1};
        tbl[7]  = '{0, 0, 8'h00, 1, 8'h22, 1, 2, 1};
        tbl[8]  = '{0, 0, 8'h00, 1, 8'h33, 1, 1, 1};
        tbl[9]  = '{0, 0, 8'h00, 1, 8'h5A, 1, 0, 0};
        tbl[10] = '{0, 0, 8'h00, 0, 8'h00, 0, 0, 0};

        // power-on reset
        model_reset();
        #12;
        cmp_all();
        rst = 1'b1;

        // asynchronous reset mid-write
        step(1, 0, 8'hA1, 0, 0);
        step(1, 0, 8'hA2, 0, 0);
        step(1, 0, 8'hA3, 1, 0);
        chk("pre_rst_dout", dout, 8'hA1);
        #2 rst = 1'b0;
        #1;
        chk("async_empty", empty, 1);
        chk("async_count", count, 0);
        chk("async_dout", dout, 0);
        chk("async_dv", dout_valid, 0);
        model_reset();
        #1 rst = 1'b1;

        // packet drain table
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].w, tbl[i].lfd, tbl[i].d, tbl[i].r, 0);
            chk($sformatf("tbl%0d_dout", i), dout, tbl[i].e_dout);
            chk($sformatf("tbl%0d_dv", i), dout_valid, tbl[i].e_dv);
            chk($sformatf("tbl%0d_cnt", i), count, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_busy", i), pkt_busy, tbl[i].e_busy);
        end

        // fill, almost_full, full, overflow
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 8'(i + 8'h40), 0, 0);
            chk("fill_af", almost_full, (i + 1) >= 14);
            chk("fill_full", full, (i + 1) == 16);
        end
        step(1, 0, 8'hEE, 0, 0);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, 16);
        step(0, 0, 0, 0, 0);
        chk("ovf_clear", overflow, 0);

        // simultaneous read/write at full: read only
        step(1, 0, 8'hEF, 1, 0);
        chk("rw_full_count", count, 15);
        chk("rw_full_flag", full, 0);
        chk("rw_full_dout", dout, 8'h40);
        step(0, 0, 0, 1, 0);
        chk("rw_full_next", dout, 8'h41);

        // simultaneous read/write at empty: write only
        step(0, 0, 0, 0, 1);
        step(1, 0, 8'h77, 1, 0);
        chk("rw_empty_count", count, 1);
        chk("rw_empty_dv", dout_valid, 0);

        // wrap-around with ordered data
        step(0, 0, 0, 0, 1);
        exp_q.delete();
        for (int i = 0; i < 15; i++) begin
            step(1, 0, 8'(i * 3), 0, 0);
            exp_q.push_back(8'(i * 3));
        end
        for (int i = 0; i < 40; i++) begin
            ed = 8'($urandom);
            step(1, 0, ed, 1, 0);
            exp_q.push_back(ed);
            chk("wrap_data", dout, exp_q.pop_front());
            chk("wrap_full", full, 0);
            chk("wrap_empty", empty, 0);
        end
        step(1, 0, 8'h99, 0, 0);
        chk("wrap_fill", full, 1);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, 7) == 0,
                 8'($urandom), $urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) == 0);
        end

        // timeout flush, and no flush when disabled
        step(0, 0, 0, 0, 1);
        step(1, 0, 8'h12, 0, 0);
        step(1, 0, 8'h34, 0, 0);
        idle_edges = 1;
        seen = 0;
        seen_b = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step(0, 0, 0, 0, 0);
            idle_edges++;
            if (timeout_b) seen_b = 1;
            if (timeout) begin
                seen = 1;
                chk("to_edge", idle_edges, 30);
                chk("to_empty", empty, 1);
                chk("to_count", count, 0);
            end
        end
        chk("to_seen", seen, 1);
        step(0, 0, 0, 0, 0);
        chk("to_one_cycle", timeout, 0);
        while (idle_edges < 100) begin
            step(0, 0, 0, 0, 0);
            idle_edges++;
            if (timeout_b) seen_b = 1;
        end
        chk("no_to_b", seen_b, 0);
        chk("count_b", count_b, 2);
        chk("empty_b", empty_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
